// File: rtl/datapath_sequencer.sv
// Layer sequencer for configurable_data_path: vertical-reg loads, pipeline wait, tile accumulation, result handshake.
// Optional feature macro SEQ_PERF_CNT_EN adds perf_stall_cnt (handshake stalls plus shift-wait cycles).
module datapath_sequencer #(
  parameter int unsigned PIPE_LAT    = 4,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TILE_W      = 8,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        cfg_com_type,
  input  logic [7:0]        cfg_kernel_size,
  input  logic [TILE_W-1:0] cfg_in_tiles,
  input  logic [TILE_W-1:0] cfg_out_tiles,
  input  logic [CNT_W-1:0]  cfg_pixels,
  input  logic              shift_done,
  input  logic              out_ready,
  output logic              virtical_reg_shift,
  output logic              virreg_input_sel,
  output logic              weight_read_en,
  output logic              acc_clear,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              cfg_err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int unsigned WAIT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [7:0] COM_CONV   = 8'h01;
  localparam logic [7:0] COM_DWCONV = 8'h02;
  localparam logic [7:0] COM_PWCONV = 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WAIT_SHIFT, S_PIPE, S_WRITE, S_FINISH
  } state_t;

  typedef struct packed {
    logic [7:0]        com_type;
    logic [TILE_W-1:0] in_tiles;
    logic [TILE_W-1:0] out_tiles;
    logic [CNT_W-1:0]  pixels;
  } cfg_t;

  state_t            state;
  cfg_t              cfg_q;
  logic [TILE_W-1:0] ic;
  logic [TILE_W-1:0] oc;
  logic [CNT_W-1:0]  pix;
  logic [WAIT_W-1:0] wait_cnt;

  logic cfg_legal;
  logic last_ic;
  logic last_pix;
  logic last_oc;

  // Legality of the incoming configuration, evaluated only when start is seen in IDLE.
  always_comb begin
    cfg_legal = 1'b1;
    if (cfg_com_type != COM_CONV && cfg_com_type != COM_DWCONV && cfg_com_type != COM_PWCONV)
      cfg_legal = 1'b0;
    if (cfg_kernel_size == 8'd0 || cfg_kernel_size > 8'(KERNEL_SIZE))
      cfg_legal = 1'b0;
    if (cfg_com_type == COM_PWCONV && cfg_kernel_size != 8'd1)
      cfg_legal = 1'b0;
    if (cfg_in_tiles == '0 || cfg_out_tiles == '0 || cfg_pixels == '0)
      cfg_legal = 1'b0;
  end

  // Depthwise layers never accumulate across input tiles.
  always_comb begin
    last_ic  = (cfg_q.com_type == COM_DWCONV) || (ic == cfg_q.in_tiles - TILE_W'(1));
    last_pix = (pix == cfg_q.pixels - CNT_W'(1));
    last_oc  = (oc == cfg_q.out_tiles - TILE_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= S_IDLE;
      cfg_q              <= '0;
      ic                 <= '0;
      oc                 <= '0;
      pix                <= '0;
      wait_cnt           <= '0;
      virtical_reg_shift <= 1'b0;
      virreg_input_sel   <= 1'b0;
      weight_read_en     <= 1'b0;
      acc_clear          <= 1'b0;
      out_valid          <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      cfg_err            <= 1'b0;
    end else begin
      virtical_reg_shift <= 1'b0;
      weight_read_en     <= 1'b0;
      acc_clear          <= 1'b0;
      done               <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (cfg_legal) begin
              cfg_q              <= '{com_type: cfg_com_type, in_tiles: cfg_in_tiles,
                                      out_tiles: cfg_out_tiles, pixels: cfg_pixels};
              cfg_err            <= 1'b0;
              busy               <= 1'b1;
              ic                 <= '0;
              oc                 <= '0;
              pix                <= '0;
              virtical_reg_shift <= 1'b1;
              weight_read_en     <= 1'b1;
              acc_clear          <= 1'b1;
              state              <= S_LOAD;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        S_LOAD: state <= S_WAIT_SHIFT;
        S_WAIT_SHIFT: begin
          if (shift_done) begin
            wait_cnt <= WAIT_W'(PIPE_LAT - 1);
            state    <= S_PIPE;
          end
        end
        S_PIPE: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - WAIT_W'(1);
          end else if (!last_ic) begin
            ic                 <= ic + TILE_W'(1);
            virreg_input_sel   <= ~virreg_input_sel;
            virtical_reg_shift <= 1'b1;
            weight_read_en     <= 1'b1;
            state              <= S_LOAD;
          end else begin
            out_valid <= 1'b1;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          // Counters advance only on the accepted handshake; the next pixel restarts accumulation.
          if (out_ready) begin
            out_valid        <= 1'b0;
            ic               <= '0;
            virreg_input_sel <= ~virreg_input_sel;
            if (last_pix && last_oc) begin
              pix   <= '0;
              oc    <= '0;
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              if (last_pix) begin
                pix <= '0;
                oc  <= oc + TILE_W'(1);
              end else begin
                pix <= pix + CNT_W'(1);
              end
              virtical_reg_shift <= 1'b1;
              weight_read_en     <= 1'b1;
              acc_clear          <= 1'b1;
              state              <= S_LOAD;
            end
          end
        end
        S_FINISH: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  // Saturating count of cycles the layer is held up by downstream or by the shift handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (state == S_IDLE && start && cfg_legal) begin
      perf_stall_cnt <= '0;
    end else if (((out_valid && !out_ready) || state == S_WAIT_SHIFT) && perf_stall_cnt != '1) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized self-checking bench for datapath_sequencer; the model tracks layer events
// (load pulses, pipeline latency, results, done) rather than FSM states.
`timescale 1ns/1ps
module tb_datapath_sequencer;
  localparam int unsigned PIPE_LAT    = 4;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned TILE_W      = 8;
  localparam int unsigned KERNEL_SIZE = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        cfg_com_type;
  logic [7:0]        cfg_kernel_size;
  logic [TILE_W-1:0] cfg_in_tiles;
  logic [TILE_W-1:0] cfg_out_tiles;
  logic [CNT_W-1:0]  cfg_pixels;
  logic              shift_done;
  logic              out_ready;
  logic              virtical_reg_shift, virreg_input_sel, weight_read_en, acc_clear;
  logic              out_valid, busy, done, cfg_err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0]       perf_stall_cnt;
`endif

  datapath_sequencer #(
    .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W), .TILE_W(TILE_W), .KERNEL_SIZE(KERNEL_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_com_type(cfg_com_type), .cfg_kernel_size(cfg_kernel_size),
    .cfg_in_tiles(cfg_in_tiles), .cfg_out_tiles(cfg_out_tiles), .cfg_pixels(cfg_pixels),
    .shift_done(shift_done), .out_ready(out_ready),
    .virtical_reg_shift(virtical_reg_shift), .virreg_input_sel(virreg_input_sel),
    .weight_read_en(weight_read_en), .acc_clear(acc_clear), .out_valid(out_valid),
    .busy(busy), .done(done), .cfg_err(cfg_err)
`ifdef SEQ_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit legal_f(input int t, input int k, input int in_t, input int out_t, input int pix);
    if (t < 1 || t > 3) return 1'b0;
    if (k < 1 || k > int'(KERNEL_SIZE)) return 1'b0;
    if (t == 3 && k != 1) return 1'b0;
    if (in_t == 0 || out_t == 0 || pix == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int pack_q(input bit q[$]);
    int v = 0;
    foreach (q[i]) v = (v << 1) | int'(q[i]);
    return v;
  endfunction

  // Layer-level reference model state
  int     cyc = 0;
  bit     exp_busy = 0, exp_err = 0, model_sel = 0;
  bit     start_pend = 0, shift_pend = 0, hs_pend = 0, done_pend = 0, waiting = 0;
  int     t_start = 0, t_shift = 0, t_hs = 0, t_done = 0;
  int     load_k = 0, results = 0, m_in_eff = 1, m_total = 1, first_lat = 0;
  bit     prev_valid = 0, prev_ready = 0;
  int     valid_run = 0, last_valid_run = 0, dones = 0, loads_all = 0;
  longint exp_perf = 0;
  bit     sel_log[$];
  bit     acc_log[$];

  always @(negedge clk) begin : monitor
    bit in_wait;
    bit load_due;
    cyc++;
    if (rst) begin
      chk("reset_outputs", {virtical_reg_shift, virreg_input_sel, weight_read_en, acc_clear,
                            out_valid, busy, done, cfg_err}, 0);
      exp_busy = 0; exp_err = 0; model_sel = 0;
      start_pend = 0; shift_pend = 0; hs_pend = 0; done_pend = 0; waiting = 0;
      prev_valid = 0; prev_ready = 0; valid_run = 0;
    end else begin
      in_wait = waiting;
      chk("cfg_err", cfg_err, exp_err);
      chk("busy", busy, exp_busy);
      chk("weight_read_en", weight_read_en, virtical_reg_shift);
      if (!exp_busy)
        chk("idle_quiet", {virtical_reg_shift, acc_clear, out_valid, done, virreg_input_sel},
            {4'b0000, model_sel});
      if (prev_valid && !prev_ready) chk("valid_held", out_valid, 1);
      if (waiting && shift_done) begin
        waiting = 0; shift_pend = 1; t_shift = cyc;
      end
      if (virtical_reg_shift) begin
        load_due = (start_pend && cyc == t_start + 1) ||
                   (shift_pend && cyc == t_shift + int'(PIPE_LAT) + 1 && (load_k % m_in_eff) != 0) ||
                   (hs_pend && cyc == t_hs + 1);
        chk("load_timing", load_due, 1);
        chk("load_sel", virreg_input_sel, model_sel ^ load_k[0]);
        chk("load_acc_clear", acc_clear, (load_k % m_in_eff) == 0);
        sel_log.push_back(virreg_input_sel);
        acc_log.push_back(acc_clear);
        load_k++; loads_all++;
        start_pend = 0; shift_pend = 0; hs_pend = 0; waiting = 1;
      end
      if (out_valid && !prev_valid) begin
        chk("result_timing", shift_pend && cyc == t_shift + int'(PIPE_LAT) + 1, 1);
        chk("result_tiles", load_k, (results + 1) * m_in_eff);
        if (results == 0) first_lat = cyc - t_start;
        shift_pend = 0;
      end
      if (out_valid) valid_run++;
      if (out_valid && out_ready) begin
        results++; last_valid_run = valid_run; valid_run = 0;
        if (results == m_total) begin done_pend = 1; t_done = cyc; end
        else begin hs_pend = 1; t_hs = cyc; end
      end
      if (start_pend && cyc > t_start + 1) begin chk("load_after_start_missing", 0, 1); start_pend = 0; end
      if (shift_pend && cyc > t_shift + int'(PIPE_LAT) + 1) begin chk("event_after_pipe_missing", 0, 1); shift_pend = 0; end
      if (hs_pend && cyc > t_hs + 1) begin chk("load_after_handshake_missing", 0, 1); hs_pend = 0; end
      if (done_pend && cyc > t_done + 1) begin chk("done_missing", 0, 1); done_pend = 0; end
      if (done) begin
        chk("done_timing", done_pend && cyc == t_done + 1, 1);
        chk("done_results", results, m_total);
        chk("done_loads", load_k, m_total * m_in_eff);
        chk("done_sel", virreg_input_sel, model_sel ^ load_k[0]);
`ifdef SEQ_PERF_CNT_EN
        chk("perf_stall_cnt", perf_stall_cnt, exp_perf);
`endif
        model_sel = model_sel ^ load_k[0];
        done_pend = 0; dones++;
      end
      if (in_wait || (out_valid && !out_ready)) exp_perf++;
      if (start && !exp_busy) begin
        if (legal_f(int'(cfg_com_type), int'(cfg_kernel_size), int'(cfg_in_tiles),
                    int'(cfg_out_tiles), int'(cfg_pixels))) begin
          exp_err = 0; exp_busy = 1; start_pend = 1; t_start = cyc;
          load_k = 0; results = 0; exp_perf = 0;
          m_in_eff = (cfg_com_type == 8'h02) ? 1 : int'(cfg_in_tiles);
          m_total  = int'(cfg_out_tiles) * int'(cfg_pixels);
          sel_log.delete(); acc_log.delete();
        end else begin
          exp_err = 1;
        end
      end
      if (done) exp_busy = 0;
      prev_valid = out_valid; prev_ready = out_ready;
    end
  end

  // shift_done responder: fixed or random delay after each load, plus spurious pulses when ignored
  int shift_cnt = 0, shift_fixed = 0;
  bit spurious_en = 0;
  initial begin
    shift_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) shift_cnt = 0;
      else if (virtical_reg_shift) shift_cnt = (shift_fixed > 0) ? shift_fixed : int'($urandom_range(1, 4));
      @(posedge clk); #1;
      if (shift_cnt > 0) begin
        shift_cnt--;
        shift_done = (shift_cnt == 0);
      end else begin
        shift_done = spurious_en && (out_valid || !busy) && ($urandom_range(0, 3) == 0);
      end
    end
  end

  // out_ready driver: 0 = always ready, 1 = random, 2 = driven by the test sequence
  int ready_mode = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (ready_mode == 0) out_ready = 1'b1;
      else if (ready_mode == 1) out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic pulse_start(input int t, input int k, input int in_t, input int out_t, input int pix);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_com_type = 8'(t); cfg_kernel_size = 8'(k);
    cfg_in_tiles = TILE_W'(in_t); cfg_out_tiles = TILE_W'(out_t); cfg_pixels = CNT_W'(pix);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < budget);
    chk(name, done, 1);
    #1;
  endtask

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int d0, l0, n;
    int t, k, in_t, out_t, pix;
    rst = 1'b1; start = 1'b0;
    cfg_com_type = '0; cfg_kernel_size = '0; cfg_in_tiles = '0; cfg_out_tiles = '0; cfg_pixels = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    chk("post_reset_busy", busy, 0);
    chk("post_reset_valid", out_valid, 0);

    // CONV k=3 in=2 out=1 pix=2, shift_done two cycles after each load
    shift_fixed = 2; ready_mode = 0; spurious_en = 0;
    d0 = dones;
    pulse_start(1, 3, 2, 1, 2);
    wait_done(500, "t1_done_timeout");
    chk("t1_loads", load_k, 4);
    chk("t1_results", results, 2);
    chk("t1_sel_pattern", pack_q(sel_log), 5);
    chk("t1_acc_pattern", pack_q(acc_log), 10);
    chk("t1_dones", dones - d0, 1);
    chk("t1_first_latency", first_lat, 15);

    // DWCONV ignores in_tiles
    pulse_start(2, 3, 4, 1, 3);
    wait_done(500, "t2_done_timeout");
    chk("t2_loads", load_k, 3);
    chk("t2_acc_pattern", pack_q(acc_log), 7);
    chk("t2_results", results, 3);

    // PWCONV with kernel 3 is rejected; a legal start clears the error
    l0 = loads_all;
    pulse_start(3, 3, 1, 1, 1);
    repeat (3) @(negedge clk); #1;
    chk("t3_cfg_err", cfg_err, 1);
    chk("t3_busy", busy, 0);
    chk("t3_no_load", loads_all - l0, 0);
    pulse_start(3, 1, 1, 1, 1);
    @(negedge clk); #1;
    chk("t3_err_cleared", cfg_err, 0);
    wait_done(500, "t3_done_timeout");

    // Downstream stalls 5 cycles on a single result
    ready_mode = 2; out_ready = 1'b0;
    pulse_start(1, 2, 1, 1, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!out_valid && n < 200);
    chk("t4_valid_seen", out_valid, 1);
    repeat (5) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done(200, "t4_done_timeout");
    chk("t4_valid_cycles", last_valid_run, 6);
    ready_mode = 0;

    // Reset while the pipeline wait is running, then a normal layer
    shift_fixed = 1;
    d0 = dones;
    pulse_start(1, 3, 2, 1, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!shift_done && n < 100);
    chk("t5_shift_seen", shift_done, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); #1;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_valid", out_valid, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t5_no_done_on_abort", dones - d0, 0);
    pulse_start(1, 1, 1, 1, 2);
    wait_done(500, "t5_done_timeout");
    chk("t5_results_after_reset", results, 2);
    chk("t5_dones", dones - d0, 1);

    // start while busy with a different configuration is ignored
    shift_fixed = 0;
    pulse_start(1, 1, 1, 2, 2);
    repeat (3) @(posedge clk);
    pulse_start(1, 1, 3, 1, 5);
    wait_done(1000, "t6_done_timeout");
    chk("t6_results", results, 4);

    // Randomized layers with random ready/shift timing and spurious shift_done
    spurious_en = 1; ready_mode = 1;
    for (int it = 0; it < 24; it++) begin
      n = int'($urandom_range(0, 9));
      t = (n < 8) ? 1 + (n % 3) : ((n == 8) ? 0 : 5);
      k = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1)) * 4 : int'($urandom_range(1, 3));
      if (t == 3 && $urandom_range(0, 3) != 0) k = 1;
      in_t  = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
      out_t = int'($urandom_range(1, 2));
      pix   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 3));
      pulse_start(t, k, in_t, out_t, pix);
      if (legal_f(t, k, in_t, out_t, pix)) begin
        wait_done(3000, "rand_done_timeout");
      end else begin
        repeat (2) @(negedge clk); #1;
        chk("rand_cfg_err", cfg_err, 1);
      end
    end
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
